qos_wrr_scheduler: RTL and testbench
====================================

QOS_WRR_SCHEDULER -- requirements
Module: qos_wrr_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: active  input  1  scheduler enable; 0 = no pops, no pushes.
REQ-004 SHALL have port: empty  input  4  empty flags of class FIFOs P0..P3 (bit i = Pi).
REQ-005 SHALL have port: data_p0..data_p3  input  12 each  show-ahead head word of each class FIFO; [11:10] = class.
REQ-006 SHALL have port: weight  input  16  per-class burst weight; weight[4i+3:4i] = Wi, 0 = class disabled.
REQ-007 SHALL have port: almost_full_out  input  1  back-pressure from the single output FIFO.
REQ-008 SHALL have port: pop  output  4  one-hot pop to class FIFOs.
REQ-009 SHALL have port: push_out  output  1  push to the output FIFO.
REQ-010 SHALL have port: data_out  output  12  word pushed to the output FIFO.
REQ-011 SHALL have port: ptr  output  2  class currently owning the grant.

Function
REQ-012 SHALL implement states IDLE and SERVE.
REQ-013 Eligible(i) SHALL be: empty[i]=0 and Wi!=0.
REQ-014 IDLE->SERVE SHALL occur when active=1, almost_full_out=0 and any class is eligible; ptr SHALL load the first eligible class searching ptr+1, ptr+2, ptr+3, ptr (mod 4); cnt=0.
REQ-015 SERVE->IDLE SHALL occur when active=0 or no class is eligible; ptr SHALL be held.
REQ-016 In SERVE, pop[ptr] SHALL be 1 (combinational, one-hot) iff active=1, almost_full_out=0, eligible(ptr) and cnt<Wptr; all other pop bits 0.
REQ-017 Each pop SHALL increment the 4-bit burst counter cnt.
REQ-018 When ptr cannot pop (empty, disabled, or cnt>=Wptr) and almost_full_out=0, ptr SHALL advance on the next edge to the next eligible class in rotating order, cnt=0; that cycle SHALL carry no pop (one-cycle switch bubble).
REQ-019 If ptr is the only eligible class and its burst is exhausted, ptr SHALL reselect itself with cnt=0.
REQ-020 almost_full_out=1 SHALL force pop=0 and hold ptr and cnt unchanged.
REQ-021 push_out and data_out SHALL be registered: one cycle after pop[i]=1, push_out=1 and data_out=data_pi as sampled at the pop edge; otherwise push_out=0 and data_out holds.
REQ-022 Latency pop->push_out SHALL be exactly 1 cycle; throughput SHALL be 1 word/cycle within a burst.
REQ-023 Weight change mid-burst SHALL take effect immediately; new Wptr<=cnt ends the burst.
REQ-024 active falling mid-burst SHALL stop pops that cycle; the push of the last accepted pop SHALL still complete.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, ptr=0, cnt=0, push_out=0, data_out=0; pop SHALL be 0 while reset=0.
REQ-026 Reset release SHALL take effect on the first rising clk edge with reset=1; ptr=0 means the first search starts at P1.

Structure
REQ-027 Package qos_pkg SHALL hold NUM_CLASS=4, DATA_W=12, CLASS_W=2, WEIGHT_W=4 and the state encoding.
REQ-028 Sub-module rr_next_sel SHALL implement the combinational rotating-priority search (inputs: eligible mask, ptr; outputs: next ptr, found).

Verification
REQ-029 W=1,1,1,1, all four FIFOs hold 2 words, almost_full_out=0 -> push order P1,P2,P3,P0,P1,P2,P3,P0, one bubble between classes.
REQ-030 W0=3,W1=1, only P0/P1 non-empty with 6 words each -> output pattern P1, then P0,P0,P0, P1, P0,P0,P0 ...
REQ-031 almost_full_out=1 for 3 cycles mid-burst at cnt=2, W=4 -> pop=0 for 3 cycles, burst resumes with 2 remaining pops, ptr unchanged.
REQ-032 W2=0, P2 non-empty, others empty -> state stays IDLE, pop=0, push_out=0.
REQ-033 reset asserted during SERVE with pop=0001 -> pop, push_out, data_out, ptr, cnt reach 0 without a clock edge.
REQ-034 active dropped after the 2nd pop of a 4-burst -> exactly 2 push_out pulses, data_out equals the 2 popped words.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared sizing, FSM encoding and weight-field helper for the QoS weighted
// round-robin scheduler.
package qos_pkg;

  localparam int NUM_CLASS = 4;
  localparam int DATA_W    = 12;
  localparam int CLASS_W   = 2;
  localparam int WEIGHT_W  = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  // Extracts Wc from the packed weight bus (weight[4c+3:4c]).
  function automatic logic [WEIGHT_W-1:0] class_weight(
    input logic [NUM_CLASS*WEIGHT_W-1:0] w,
    input logic [CLASS_W-1:0]            c
  );
    return w[c*WEIGHT_W +: WEIGHT_W];
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Rotating-priority search: returns the first eligible class scanning
// ptr+1, ptr+2, ptr+3 and finally ptr itself.
module rr_next_sel
  import qos_pkg::*;
(
  input  logic [NUM_CLASS-1:0] eligible,
  input  logic [CLASS_W-1:0]   ptr,
  output logic [CLASS_W-1:0]   next_ptr,
  output logic                 found
);

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    next_ptr = ptr;
    found    = 1'b0;
    for (int k = NUM_CLASS; k >= 1; k--) begin
      if (eligible[ptr + CLASS_W'(k)]) begin
        next_ptr = ptr + CLASS_W'(k);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin scheduler: drains four show-ahead class FIFOs in
// bursts of up to Wi words into a single output FIFO.
module qos_wrr_scheduler
  import qos_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [3:0]  empty,
  input  logic [11:0] data_p0,
  input  logic [11:0] data_p1,
  input  logic [11:0] data_p2,
  input  logic [11:0] data_p3,
  input  logic [15:0] weight,
  input  logic        almost_full_out,
  output logic [3:0]  pop,
  output logic        push_out,
  output logic [11:0] data_out,
  output logic [1:0]  ptr
);

  // Handshake: a class FIFO word is consumed on the rising edge where
  // pop[i]=1 (its head must be valid, i.e. empty[i]=0); the output FIFO
  // accepts a word on every edge where push_out=1 and is assumed ready while
  // almost_full_out=0, which leaves room for the one word already in flight.

  logic [0:0]           state_q;
  logic [CLASS_W-1:0]   ptr_q;
  logic [WEIGHT_W-1:0]  cnt_q;
  logic [NUM_CLASS-1:0] eligible;
  logic [WEIGHT_W-1:0]  cur_w;
  logic [CLASS_W-1:0]   next_ptr;
  logic                 found;
  logic                 can_pop;
  logic [DATA_W-1:0]    head;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      eligible[i] = ~empty[i] & (class_weight(weight, CLASS_W'(i)) != '0);
    end
  end

  rr_next_sel u_rr_next_sel (
    .eligible (eligible),
    .ptr      (ptr_q),
    .next_ptr (next_ptr),
    .found    (found)
  );

  // Weight is read live so a mid-burst change ends or extends the burst now.
  assign cur_w   = class_weight(weight, ptr_q);
  assign can_pop = (state_q == ST_SERVE) & active & ~almost_full_out &
                   eligible[ptr_q] & (cnt_q < cur_w);
  assign pop     = can_pop ? (4'b0001 << ptr_q) : 4'b0000;
  assign ptr     = ptr_q;

  always_comb begin
    case (ptr_q)
      2'd0:    head = data_p0;
      2'd1:    head = data_p1;
      2'd2:    head = data_p2;
      default: head = data_p3;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_out <= 1'b0;
      data_out <= '0;
    end else begin
      push_out <= can_pop;
      if (can_pop) data_out <= head;
    end
  end

  // A non-popping SERVE cycle (burst done, class drained or disabled) is the
  // switch bubble: the grant moves on, or back to itself if it is alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (active && !almost_full_out && found) begin
            state_q <= ST_SERVE;
            ptr_q   <= next_ptr;
            cnt_q   <= '0;
          end
        end
        default: begin
          if (!active || !found) begin
            state_q <= ST_IDLE;
          end else if (almost_full_out) begin
            state_q <= ST_SERVE;
          end else if (can_pop) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            ptr_q <= next_ptr;
            cnt_q <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Directed bench for qos_wrr_scheduler with a behavioural show-ahead FIFO
// model per class and a capture queue of pushed words.
module tb_qos_wrr_scheduler;
  import qos_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        active = 1'b0;
  logic        almost_full_out = 1'b0;
  logic [3:0]  empty;
  logic [11:0] data_p0, data_p1, data_p2, data_p3;
  logic [15:0] weight = 16'h0000;
  logic [3:0]  pop;
  logic        push_out;
  logic [11:0] data_out;
  logic [1:0]  ptr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [11:0] mem [4][16];
  int          lvl [4];
  int          rd  [4];
  logic [11:0] got_q [$];
  int          got_t [$];
  logic [11:0] exp_q [$];

  qos_wrr_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .active          (active),
    .empty           (empty),
    .data_p0         (data_p0),
    .data_p1         (data_p1),
    .data_p2         (data_p2),
    .data_p3         (data_p3),
    .weight          (weight),
    .almost_full_out (almost_full_out),
    .pop             (pop),
    .push_out        (push_out),
    .data_out        (data_out),
    .ptr             (ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) empty[i] = (rd[i] >= lvl[i]);
    data_p0 = mem[0][4'(rd[0])];
    data_p1 = mem[1][4'(rd[1])];
    data_p2 = mem[2][4'(rd[2])];
    data_p3 = mem[3][4'(rd[3])];
  end

  function automatic logic [11:0] word(input int c, input int k);
    return {2'(c), 10'(k)};
  endfunction

  // driver tasks
  task automatic fifo_load(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      mem[c][lvl[c]] = word(c, k + 1);
      lvl[c]++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    active = 1'b0;
    almost_full_out = 1'b0;
    weight = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      lvl[i] = 0;
      rd[i] = 0;
      for (int k = 0; k < 16; k++) mem[i][k] = 12'h000;
    end
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cyc = 0;
  endtask

  // One clock: sample pop mid-cycle, then retire popped words and capture push.
  task automatic tick(output logic [3:0] p);
    @(negedge clk);
    p = pop;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (p[i]) rd[i]++;
    if (push_out) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL reset_pop got=%b exp=0000", pop); end
    checks++; if (push_out !== 1'b0) begin failures++; $display("FAIL reset_push got=%b exp=0", push_out); end
    checks++; if (data_out !== 12'h000) begin failures++; $display("FAIL reset_data got=%h exp=000", data_out); end
    checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] p;
    int order [4] = '{1, 2, 3, 0};
    apply_reset();
    weight = 16'h1111;
    for (int c = 0; c < 4; c++) fifo_load(c, 2);
    active = 1'b1;
    repeat (20) tick(p);
    for (int k = 1; k <= 2; k++)
      for (int j = 0; j < 4; j++) exp_q.push_back(word(order[j], k));
    checks++; if (got_q.size() != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      checks++; if (got_t[i] != 2 + 2 * i) begin failures++; $display("FAIL rr_time%0d got=%0d exp=%0d", i, got_t[i], 2 + 2 * i); end
    end
  endtask

  task automatic test_weighted();
    logic [3:0] p;
    int seq [12] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
    int idx [4] = '{0, 0, 0, 0};
    apply_reset();
    weight = 16'h0013;
    fifo_load(0, 6);
    fifo_load(1, 6);
    active = 1'b1;
    repeat (30) tick(p);
    for (int i = 0; i < 12; i++) begin
      idx[seq[i]]++;
      exp_q.push_back(word(seq[i], idx[seq[i]]));
    end
    checks++; if (got_q.size() != 12) begin failures++; $display("FAIL wrr_count got=%0d exp=12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrr_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_almost_full();
    logic [3:0] p;
    apply_reset();
    weight = 16'h0004;
    fifo_load(0, 4);
    active = 1'b1;
    tick(p);
    checks++; if (p !== 4'b0000) begin failures++; $display("FAIL af_enter got=%b exp=0000", p); end
    repeat (2) begin
      tick(p);
      checks++; if (p !== 4'b0001) begin failures++; $display("FAIL af_pre got=%b exp=0001", p); end
    end
    almost_full_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(p);
      checks++; if (p !== 4'b0000) begin failures++; $display("FAIL af_hold_pop%0d got=%b exp=0000", i, p); end
      checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL af_hold_ptr%0d got=%0d exp=0", i, ptr); end
    end
    checks++; if (dut.cnt_q !== 4'd2) begin failures++; $display("FAIL af_hold_cnt got=%0d exp=2", dut.cnt_q); end
    almost_full_out = 1'b0;
    repeat (2) begin
      tick(p);
      checks++; if (p !== 4'b0001) begin failures++; $display("FAIL af_resume got=%b exp=0001", p); end
    end
    tick(p);
    checks++; if (p !== 4'b0000) begin failures++; $display("FAIL af_done got=%b exp=0000", p); end
    for (int k = 1; k <= 4; k++) exp_q.push_back(word(0, k));
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL af_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL af_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_disabled();
    logic [3:0] p;
    apply_reset();
    weight = 16'h1011;
    fifo_load(2, 3);
    active = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(p);
      checks++; if (p !== 4'b0000) begin failures++; $display("FAIL dis_pop%0d got=%b exp=0000", i, p); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL dis_push got=%0d exp=0", got_q.size()); end
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL dis_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_weight_change();
    logic [3:0] p;
    logic [3:0] exp_p [5] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    apply_reset();
    weight = 16'h0004;
    fifo_load(0, 6);
    active = 1'b1;
    tick(p);
    tick(p);
    checks++; if (p !== 4'b0001) begin failures++; $display("FAIL wc_first got=%b exp=0001", p); end
    weight = 16'h0001;
    #1;
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL wc_immediate got=%b exp=0000", pop); end
    for (int i = 1; i < 5; i++) begin
      tick(p);
      checks++; if (p !== exp_p[i]) begin failures++; $display("FAIL wc_pop%0d got=%b exp=%b", i, p, exp_p[i]); end
    end
  endtask

  task automatic test_active_drop();
    logic [3:0] p;
    apply_reset();
    weight = 16'h0004;
    fifo_load(0, 4);
    active = 1'b1;
    repeat (3) tick(p);
    checks++; if (p !== 4'b0001) begin failures++; $display("FAIL ad_second got=%b exp=0001", p); end
    active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(p);
      checks++; if (p !== 4'b0000) begin failures++; $display("FAIL ad_pop%0d got=%b exp=0000", i, p); end
    end
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL ad_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== word(0, i + 1)) begin failures++; $display("FAIL ad_word%0d got=%h exp=%h", i, got_q[i], word(0, i + 1)); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] p;
    apply_reset();
    weight = 16'h0004;
    fifo_load(0, 4);
    active = 1'b1;
    repeat (2) tick(p);
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL ar_pre_pop got=%b exp=0001", pop); end
    checks++; if (data_out !== word(0, 1)) begin failures++; $display("FAIL ar_pre_data got=%h exp=%h", data_out, word(0, 1)); end
    #1 reset = 1'b0;
    #1;
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL ar_pop got=%b exp=0000", pop); end
    checks++; if (push_out !== 1'b0) begin failures++; $display("FAIL ar_push got=%b exp=0", push_out); end
    checks++; if (data_out !== 12'h000) begin failures++; $display("FAIL ar_data got=%h exp=000", data_out); end
    checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL ar_ptr got=%0d exp=0", ptr); end
    checks++; if (dut.cnt_q !== 4'd0) begin failures++; $display("FAIL ar_cnt got=%0d exp=0", dut.cnt_q); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_almost_full();
    test_disabled();
    test_weight_change();
    test_active_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
